// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin arbiter in front of a single Wishbone slave port.
// Registered grant, combinational request/response muxing, and a stall watchdog.
module wb_rr_arbiter #(
  parameter int          DATA_WIDTH     = 16,
  parameter int          ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0 (host-bus bridge)
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wr_data_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic [DATA_WIDTH-1:0] m0_rd_data_o,
  // master 1 (on-chip master)
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wr_data_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [DATA_WIDTH-1:0] m1_rd_data_o,
  // shared slave port
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_wr_data_o,
  input  logic [DATA_WIDTH-1:0] s_rd_data_i,
  input  logic                  s_ack_i,
  // status / debug
  output logic [1:0]            grant_o,
  output logic                  busy_o,
  output logic [1:0]            state_o
);

  // Handshake: a beat is offered while cyc&stb are high and completes on the
  // cycle ack is high (ack is the ready); cyc held high locks the bus for the owner.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_ABORT  = 2'd3
  } state_t;

  localparam int          TW       = 16;
  localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TMO_LAST = WD_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

  state_t        state_q, state_d;
  logic          last_owner_q, last_owner_d;
  logic [TW-1:0] timer_q, timer_d;

  logic own_cyc;
  logic own_stb;

  assign own_cyc = (state_q == ST_GRANT1) ? m1_cyc_i : m0_cyc_i;
  assign own_stb = (state_q == ST_GRANT1) ? m1_stb_i : m0_stb_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      timer_q      <= timer_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    timer_d      = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (m0_cyc_i && m1_cyc_i) begin
          // tie goes to whoever did not own the bus last
          if (last_owner_q) begin
            state_d      = ST_GRANT0;
            last_owner_d = 1'b0;
          end else begin
            state_d      = ST_GRANT1;
            last_owner_d = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_d      = ST_GRANT0;
          last_owner_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d      = ST_GRANT1;
          last_owner_d = 1'b1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (!own_stb || s_ack_i) begin
          timer_d = '0;
        end else if (WD_EN && (timer_q == TMO_LAST)) begin
          state_d = ST_ABORT;
          timer_d = '0;
        end else if (WD_EN) begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Output logic; everything held low while reset is asserted
  always_comb begin
    s_cyc_o      = 1'b0;
    s_stb_o      = 1'b0;
    s_we_o       = 1'b0;
    s_addr_o     = '0;
    s_wr_data_o  = '0;
    m0_ack_o     = 1'b0;
    m0_err_o     = 1'b0;
    m0_rd_data_o = '0;
    m1_ack_o     = 1'b0;
    m1_err_o     = 1'b0;
    m1_rd_data_o = '0;
    grant_o      = 2'b00;
    busy_o       = 1'b0;
    state_o      = 2'b00;
    if (!rst) begin
      state_o = state_q;
      unique case (state_q)
        ST_GRANT0: begin
          grant_o      = 2'b01;
          busy_o       = 1'b1;
          s_cyc_o      = m0_cyc_i;
          s_stb_o      = m0_stb_i;
          s_we_o       = m0_we_i & m0_stb_i;
          s_addr_o     = m0_addr_i;
          s_wr_data_o  = m0_wr_data_i;
          m0_ack_o     = s_ack_i & m0_stb_i;
          m0_rd_data_o = s_rd_data_i;
        end
        ST_GRANT1: begin
          grant_o      = 2'b10;
          busy_o       = 1'b1;
          s_cyc_o      = m1_cyc_i;
          s_stb_o      = m1_stb_i;
          s_we_o       = m1_we_i & m1_stb_i;
          s_addr_o     = m1_addr_i;
          s_wr_data_o  = m1_wr_data_i;
          m1_ack_o     = s_ack_i & m1_stb_i;
          m1_rd_data_o = s_rd_data_i;
        end
        ST_ABORT: begin
          // last_owner_q still names the master whose access was aborted
          busy_o   = 1'b1;
          m0_err_o = ~last_owner_q;
          m1_err_o = last_owner_q;
        end
        default: begin
          busy_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: vector table, directed multi-cycle sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_wb_rr_arbiter;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int TMO = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  logic          m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wr = '0;
  logic          m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wr = '0;
  logic [DW-1:0] s_rd = '0;
  logic          s_ack = 0;

  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [DW-1:0] m0_rd, m1_rd;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wr;
  logic [1:0]    grant, state;
  logic          busy;

  wb_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_wr_data_i(m0_wr), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rd_data_o(m0_rd),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_wr_data_i(m1_wr), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rd_data_o(m1_rd),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr),
    .s_wr_data_o(s_wr), .s_rd_data_i(s_rd), .s_ack_i(s_ack),
    .grant_o(grant), .busy_o(busy), .state_o(state)
  );

  logic [73:0] dut_vec;
  assign dut_vec = {grant, busy, s_cyc, s_stb, s_we, s_addr, s_wr,
                    m0_ack, m0_err, m0_rd, m1_ack, m1_err, m1_rd};

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    s_ack = 0; s_rd = '0;
    m0_addr = 16'h1234; m0_wr = 16'hBEEF;
    m1_addr = 16'h5678; m1_wr = 16'hCAFE;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    sample();
    chk("reset_outputs", dut_vec, '0);
    next_cycle();
    next_cycle();
    rst = 0;
  endtask

  // behavioural model: who owns the bus, and how long the owner has stalled
  int md_owner = -1;
  bit md_abort = 0;
  int md_who   = 0;
  int md_last  = 1;
  int md_wait  = 0;

  function automatic logic [73:0] model_out();
    logic [1:0] g = 2'b00;
    logic b = 0, sc = 0, ss = 0, sw = 0, a0 = 0, e0 = 0, a1 = 0, e1 = 0;
    logic [15:0] sa = '0, sd = '0, r0 = '0, r1 = '0;
    if (!rst) begin
      if (md_abort) begin
        b = 1;
        if (md_who == 0) e0 = 1; else e1 = 1;
      end else if (md_owner == 0) begin
        g = 2'b01; b = 1; sc = m0_cyc; ss = m0_stb; sw = m0_we & m0_stb;
        sa = m0_addr; sd = m0_wr; a0 = s_ack & m0_stb; r0 = s_rd;
      end else if (md_owner == 1) begin
        g = 2'b10; b = 1; sc = m1_cyc; ss = m1_stb; sw = m1_we & m1_stb;
        sa = m1_addr; sd = m1_wr; a1 = s_ack & m1_stb; r1 = s_rd;
      end
    end
    return {g, b, sc, ss, sw, sa, sd, a0, e0, r0, a1, e1, r1};
  endfunction

  task automatic model_step();
    bit c, s;
    if (rst) begin
      md_owner = -1; md_abort = 0; md_last = 1; md_wait = 0;
    end else if (md_abort) begin
      md_abort = 0; md_wait = 0;
    end else if (md_owner < 0) begin
      if (m0_cyc && m1_cyc) md_owner = 1 - md_last;
      else if (m0_cyc)      md_owner = 0;
      else if (m1_cyc)      md_owner = 1;
      if (md_owner >= 0) md_last = md_owner;
      md_wait = 0;
    end else begin
      c = (md_owner == 1) ? m1_cyc : m0_cyc;
      s = (md_owner == 1) ? m1_stb : m0_stb;
      if (!c) begin
        md_owner = -1; md_wait = 0;
      end else if (s && !s_ack) begin
        md_wait++;
        if (md_wait >= TMO) begin
          md_abort = 1; md_who = md_owner; md_owner = -1; md_wait = 0;
        end
      end else begin
        md_wait = 0;
      end
    end
  endtask

  // vector table
  typedef struct {
    logic c0, s0, w0, c1, s1, ack;
    logic [1:0] g;
    logic a0, a1, sc, ss;
    logic [15:0] sa, sd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic c0, s0, w0, c1, s1, ack, input logic [1:0] g,
                              input logic a0, a1, sc, ss, input logic [15:0] sa, sd);
    vec_t v;
    v.c0 = c0; v.s0 = s0; v.w0 = w0; v.c1 = c1; v.s1 = s1; v.ack = ack;
    v.g = g; v.a0 = a0; v.a1 = a1; v.sc = sc; v.ss = ss; v.sa = sa; v.sd = sd;
    return v;
  endfunction

  task automatic run_table(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0; m0_we = tbl[i].w0;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1; s_ack = tbl[i].ack;
      sample();
      chk($sformatf("tbl[%0d].grant", i), grant, tbl[i].g);
      chk($sformatf("tbl[%0d].m0_ack", i), m0_ack, tbl[i].a0);
      chk($sformatf("tbl[%0d].m1_ack", i), m1_ack, tbl[i].a1);
      chk($sformatf("tbl[%0d].err", i), {m0_err, m1_err}, 2'b00);
      chk($sformatf("tbl[%0d].s_cyc_stb", i), {s_cyc, s_stb}, {tbl[i].sc, tbl[i].ss});
      chk($sformatf("tbl[%0d].s_addr", i), s_addr, tbl[i].sa);
      chk($sformatf("tbl[%0d].s_wr_data", i), s_wr, tbl[i].sd);
      next_cycle();
    end
  endtask

  initial begin
    // T1: single m0 write, slave acks two cycles after strobe (rows 0..5)
    tbl.push_back(mk(1,1,1, 0,0, 0, 2'b00, 0,0, 0,0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1,1,1, 0,0, 0, 2'b01, 0,0, 1,1, 16'h1234, 16'hBEEF));
    tbl.push_back(mk(1,1,1, 0,0, 0, 2'b01, 0,0, 1,1, 16'h1234, 16'hBEEF));
    tbl.push_back(mk(1,1,1, 0,0, 1, 2'b01, 1,0, 1,1, 16'h1234, 16'hBEEF));
    tbl.push_back(mk(0,0,0, 0,0, 0, 2'b01, 0,0, 0,0, 16'h1234, 16'hBEEF));
    tbl.push_back(mk(0,0,0, 0,0, 0, 2'b00, 0,0, 0,0, 16'h0000, 16'h0000));
    // T2: simultaneous requests alternate 01,10,01,10 with an idle gap (rows 6..18)
    tbl.push_back(mk(1,1,0, 1,1, 0, 2'b00, 0,0, 0,0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1,1,0, 1,1, 1, 2'b01, 1,0, 1,1, 16'h1234, 16'hBEEF));
    tbl.push_back(mk(0,0,0, 1,1, 0, 2'b01, 0,0, 0,0, 16'h1234, 16'hBEEF));
    tbl.push_back(mk(1,1,0, 1,1, 0, 2'b00, 0,0, 0,0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1,1,0, 1,1, 1, 2'b10, 0,1, 1,1, 16'h5678, 16'hCAFE));
    tbl.push_back(mk(1,1,0, 0,0, 0, 2'b10, 0,0, 0,0, 16'h5678, 16'hCAFE));
    tbl.push_back(mk(1,1,0, 1,1, 0, 2'b00, 0,0, 0,0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1,1,0, 1,1, 1, 2'b01, 1,0, 1,1, 16'h1234, 16'hBEEF));
    tbl.push_back(mk(0,0,0, 1,1, 0, 2'b01, 0,0, 0,0, 16'h1234, 16'hBEEF));
    tbl.push_back(mk(0,0,0, 1,1, 0, 2'b00, 0,0, 0,0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0,0,0, 1,1, 1, 2'b10, 0,1, 1,1, 16'h5678, 16'hCAFE));
    tbl.push_back(mk(0,0,0, 0,0, 0, 2'b10, 0,0, 0,0, 16'h5678, 16'hCAFE));
    tbl.push_back(mk(0,0,0, 0,0, 0, 2'b00, 0,0, 0,0, 16'h0000, 16'h0000));

    do_reset();
    run_table(0, 5);
    do_reset();
    run_table(6, 18);

    // T3: m0 locks the bus for three read beats while m1 waits
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    sample(); chk("t3_idle_grant", grant, 2'b00); next_cycle();
    for (int k = 1; k <= 3; k++) exp_q.push_back(DW'(k));
    for (int k = 1; k <= 3; k++) begin
      s_ack = 1; s_rd = DW'(k);
      sample();
      chk("t3_grant_m0", grant, 2'b01);
      chk("t3_m0_ack", m0_ack, 1'b1);
      chk("t3_m1_quiet", {m1_ack, m1_err, m1_rd}, '0);
      if (m0_ack && exp_q.size() > 0) chk("t3_m0_rd_data", m0_rd, exp_q.pop_front());
      next_cycle();
    end
    chk("t3_all_beats_seen", exp_q.size(), 0);
    m0_cyc = 0; m0_stb = 0; s_ack = 0; s_rd = '0;
    sample(); chk("t3_drop_cycle_grant", grant, 2'b01); chk("t3_m1_no_ack", m1_ack, 1'b0); next_cycle();
    sample(); chk("t3_gap_idle", {grant, busy}, 3'b000); next_cycle();
    s_ack = 1; s_rd = 16'h0055;
    sample();
    chk("t3_grant_m1", grant, 2'b10);
    chk("t3_m1_ack", m1_ack, 1'b1);
    chk("t3_m1_rd_data", m1_rd, 16'h0055);
    chk("t3_m0_rd_zero", m0_rd, 16'h0000);
    next_cycle();
    clear_inputs();
    next_cycle();

    // T4: slave never acks m1 -> abort after TMO stalled strobes
    do_reset();
    m1_cyc = 1; m1_stb = 1;
    sample(); chk("t4_idle", grant, 2'b00); next_cycle();
    for (int k = 0; k < TMO; k++) begin
      sample();
      chk($sformatf("t4_stall%0d", k), {grant, s_stb, m1_err}, {2'b10, 1'b1, 1'b0});
      next_cycle();
    end
    sample();
    chk("t4_abort_err", {m0_err, m1_err}, 2'b01);
    chk("t4_abort_bus", {grant, busy, s_cyc, s_stb}, {2'b00, 1'b1, 1'b0, 1'b0});
    next_cycle();
    m1_cyc = 0; m1_stb = 0; m0_cyc = 1; m0_stb = 1;
    sample(); chk("t4_post_idle", {grant, busy, m1_err}, 4'b0000); next_cycle();
    s_ack = 1;
    sample(); chk("t4_m0_served", {grant, m0_ack, m0_err}, {2'b01, 1'b1, 1'b0}); next_cycle();
    clear_inputs();
    next_cycle();

    // T5: reset mid-beat forces everything low; pending m1 is served after release
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 1;
    sample(); next_cycle();
    sample(); chk("t5_m0_granted", {grant, s_cyc, s_we}, {2'b01, 1'b1, 1'b1});
    next_cycle();
    rst = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
    sample(); chk("t5_rst_outputs_a", dut_vec, '0); next_cycle();
    sample(); chk("t5_rst_outputs_b", dut_vec, '0); next_cycle();
    rst = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0; s_ack = 0;
    sample(); chk("t5_release_idle", {grant, busy}, 3'b000); next_cycle();
    sample(); chk("t5_m1_first", grant, 2'b10); next_cycle();
    clear_inputs();
    next_cycle();

    // T6: ack lands on the last cycle before timeout -> ack wins, no error
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    sample(); next_cycle();
    for (int k = 0; k < TMO - 1; k++) begin
      sample(); chk($sformatf("t6_stall%0d", k), {m0_ack, m0_err}, 2'b00); next_cycle();
    end
    s_ack = 1;
    sample(); chk("t6_ack_wins", {m0_ack, m0_err}, 2'b10); next_cycle();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    sample(); chk("t6_no_abort", {grant, m0_err, m1_err}, {2'b01, 2'b00}); next_cycle();
    sample(); chk("t6_back_idle", {grant, busy}, 3'b000); next_cycle();

    // randomized traffic against the model
    do_reset();
    md_owner = -1; md_abort = 0; md_last = 1; md_wait = 0;
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      if (m0_cyc) m0_cyc = ($urandom_range(0, 5) != 0); else m0_cyc = ($urandom_range(0, 2) == 0);
      if (m1_cyc) m1_cyc = ($urandom_range(0, 5) != 0); else m1_cyc = ($urandom_range(0, 2) == 0);
      m0_stb = m0_cyc && ($urandom_range(0, 3) != 0);
      m1_stb = m1_cyc && ($urandom_range(0, 3) != 0);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_addr = 16'($urandom); m1_addr = 16'($urandom);
      m0_wr = 16'($urandom); m1_wr = 16'($urandom);
      s_rd = 16'($urandom);
      s_ack = ($urandom_range(0, 3) == 0);
      sample();
      chk($sformatf("rand[%0d].outputs", n), dut_vec, model_out());
      model_step();
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
